dmem_param: RTL

Parametrised successor of the processor's 256×8 data RAM. Word width and depth are configurable, and writes are byte-lane masked. Read-during-write behaviour is selectable, and a hardware clear sequencer zeroes the array after reset or on request. It sits on the core's load/store path as a one-clock synchronous-read, synchronous-write data memory, with a `busy` flag the core must respect.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_lane.sv | 55 +++++
 rtl/dmem_param.sv | 108 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the parametrised data memory.
// Read-during-write modes and clear-sequencer state encodings.
package dmem_pkg;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/dmem_lane.sv
// One 8-bit byte lane: write port plus registered read port,
// with optional same-address bypass of the incoming byte.
module dmem_lane
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int RDW_MODE = RDW_OLD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [7:0] mem [DEPTH] = '{default: '0};
   logic [7:0] rdata_q;
   logic [7:0] rdata_d;
   logic       same;

   always_comb begin
      same    = we && (waddr == raddr);
      rdata_d = rdata_q;
      if (re) begin
         // New mode forwards this lane's byte only when the lane is written
         if (RDW_MODE == RDW_NEW && same) begin
            rdata_d = wdata;
         end else begin
            rdata_d = mem[raddr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_param.sv
// Byte-masked synchronous data memory with a hardware clear sweep.
// The sweep owns the write port while busy; core accesses are dropped.
module dmem_param
   import dmem_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int RDW_MODE   = RDW_OLD,
   parameter int CLR_ON_RST = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   output logic                  busy,
   input  logic                  wen,
   input  logic [DATA_W/8-1:0]   wbe,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  ren,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_W-1:0]     rdata,
   output logic                  rvalid
);

   localparam int NLANE = DATA_W / 8;

   state_t              state_q;
   state_t              state_d;
   logic [ADDR_W-1:0]   cnt_q;
   logic [ADDR_W-1:0]   cnt_d;
   logic                rvalid_q;
   logic                rvalid_d;

   logic                clearing;
   logic                access;
   logic                lane_re;
   logic [ADDR_W-1:0]   lane_waddr;
   logic [DATA_W-1:0]   lane_wdata;
   logic [NLANE-1:0]    lane_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (clr) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (&cnt_q) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      clearing   = (state_q == ST_CLEAR) && !rst;
      // clr wins over a same-cycle access
      access     = (state_q == ST_IDLE) && !clr && !rst;
      lane_re    = ren && access;
      lane_waddr = clearing ? cnt_q : waddr;
      lane_wdata = clearing ? '0 : wdata;
      lane_we    = '0;
      if (clearing) begin
         lane_we = '1;
      end else if (wen && access) begin
         lane_we = wbe;
      end
      rvalid_d   = lane_re;
   end

   for (genvar i = 0; i < NLANE; i++) begin : g_lane
      dmem_lane #(
         .ADDR_W   (ADDR_W),
         .RDW_MODE (RDW_MODE)
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .we    (lane_we[i]),
         .waddr (lane_waddr),
         .wdata (lane_wdata[8*i +: 8]),
         .re    (lane_re),
         .raddr (raddr),
         .rdata (rdata[8*i +: 8])
      );
   end

   assign busy   = (state_q == ST_CLEAR);
   assign rvalid = rvalid_q;

endmodule
